// File: rtl/sa_cache_pkg.sv
// Shared definitions for the four-way set-associative cache: line geometry,
// per-way metadata bit positions and the controller state encoding.
package sa_cache_pkg;

    localparam int LINE_SIZE_BITS = 16 * 8;
    localparam int LINE_WIDTH     = LINE_SIZE_BITS / 32;  // 32-bit words per line

    localparam int META_VALID = 0;
    localparam int META_DIRTY = 1;
    localparam int META_USE   = 2;
    localparam int META_BITS  = 3;

    typedef enum logic {
        IDLE = 1'b0,
        MISS = 1'b1
    } state_t;

endpackage

// File: rtl/sa_way_match.sv
// Single-way hit detector: stored tag equals request tag and the way is valid.
module sa_way_match #(
    parameter int TAG_BITS = 20
) (
    input  logic [TAG_BITS-1:0] way_tag,
    input  logic [TAG_BITS-1:0] req_tag,
    input  logic                valid,
    output logic                hit
);

    assign hit = valid && (way_tag == req_tag);

endmodule

// File: rtl/sa_cache_core.sv
// Four-way set-associative write-allocate data cache with use-bit replacement.
// Write-back dirty tracking and eviction are built only when SA_CACHE_WRITEBACK_EN is defined.
module sa_cache_core
    import sa_cache_pkg::*;
#(
    parameter int SETS            = 256,
    parameter int WAYS            = 4,
    parameter int LINE_SIZE_BYTES = 16,
    parameter int TAG_BITS        = 20,
    parameter int INDEX_BITS      = 8,
    parameter int OFFSET_BITS     = 4,
    parameter int DATA_WIDTH      = 32,
    parameter int ADDRESS_WIDTH   = TAG_BITS + INDEX_BITS + OFFSET_BITS
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_req,
    input  logic [TAG_BITS-1:0]          i_tag,
    input  logic [INDEX_BITS-1:0]        i_index,
    input  logic [OFFSET_BITS-1:0]       i_offset,
    input  logic                         memRW,
    input  logic [DATA_WIDTH-1:0]        dataW,
    input  logic [LINE_SIZE_BYTES*8-1:0] i_memory_line,
    input  logic                         i_memory_response,
    output logic [DATA_WIDTH-1:0]        o_data,
    output logic                         o_valid,
    output logic [LINE_SIZE_BYTES*8-1:0] line_data,
    output logic                         cache_miss,
    output logic                         o_evict,
    output logic [LINE_SIZE_BYTES*8-1:0] o_evict_data,
    output logic [ADDRESS_WIDTH-1:0]     o_evict_addr
);

    localparam int LINE_BITS     = LINE_SIZE_BYTES * 8;
    localparam int WAY_BITS      = $clog2(WAYS);
    localparam int WORD_SEL_BITS = OFFSET_BITS - 2;

    logic [META_BITS-1:0] meta  [WAYS][SETS];
    logic [TAG_BITS-1:0]  tags  [WAYS][SETS];
    logic [LINE_BITS-1:0] lines [WAYS][SETS];

    state_t                   state, state_next;
    logic [WAYS-1:0]          hit;
    logic                     any_hit;
    logic [WAY_BITS-1:0]      hit_way, victim;
    logic                     victim_found, clear_use;
    logic [LINE_BITS-1:0]     hit_line, wr_line;
    logic [DATA_WIDTH-1:0]    rd_word;
    logic [WORD_SEL_BITS-1:0] word_sel;
    logic                     do_hit, do_fill;
    logic                     unused_offset;

    assign word_sel      = i_offset[OFFSET_BITS-1:2];
    assign unused_offset = ^i_offset[1:0];

    for (genvar w = 0; w < WAYS; w++) begin : g_match
        sa_way_match #(.TAG_BITS(TAG_BITS)) u_match (
            .way_tag (tags[w][i_index]),
            .req_tag (i_tag),
            .valid   (meta[w][i_index][META_VALID]),
            .hit     (hit[w])
        );
    end

    // Hit vector is one-hot, so the last matching way is the only one.
    always_comb begin
        hit_line = '0;
        hit_way  = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (hit[w]) begin
                hit_line = lines[w][i_index];
                hit_way  = WAY_BITS'(w);
            end
        end
    end

    assign any_hit   = |hit;
    assign line_data = hit_line;
    assign rd_word   = hit_line[int'(word_sel)*DATA_WIDTH +: DATA_WIDTH];

    always_comb begin
        wr_line = hit_line;
        wr_line[int'(word_sel)*DATA_WIDTH +: DATA_WIDTH] = dataW;
    end

    // Victim: lowest invalid way, else lowest unused way, else way 0 with a use-bit sweep.
    always_comb begin
        victim       = '0;
        victim_found = 1'b0;
        clear_use    = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (!victim_found && !meta[w][i_index][META_VALID]) begin
                victim       = WAY_BITS'(w);
                victim_found = 1'b1;
            end
        end
        for (int w = 0; w < WAYS; w++) begin
            if (!victim_found && !meta[w][i_index][META_USE]) begin
                victim       = WAY_BITS'(w);
                victim_found = 1'b1;
            end
        end
        if (!victim_found) begin
            clear_use = 1'b1;
        end
    end

    assign do_hit  = (state == IDLE) && i_req && any_hit;
    assign do_fill = (state == MISS) && i_memory_response;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (i_req && !any_hit) state_next = MISS;
            MISS: if (i_memory_response) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign cache_miss = (state == MISS);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int w = 0; w < WAYS; w++) begin
                for (int s = 0; s < SETS; s++) begin
                    meta[w][s] <= '0;
                end
            end
        end else if (do_hit) begin
            meta[hit_way][i_index][META_USE] <= 1'b1;
`ifdef SA_CACHE_WRITEBACK_EN
            if (memRW) meta[hit_way][i_index][META_DIRTY] <= 1'b1;
`endif
        end else if (do_fill) begin
            if (clear_use) begin
                for (int w = 0; w < WAYS; w++) begin
                    meta[w][i_index][META_USE] <= 1'b0;
                end
            end
            meta[victim][i_index][META_VALID] <= 1'b1;
            meta[victim][i_index][META_DIRTY] <= 1'b0;
            meta[victim][i_index][META_USE]   <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_hit && memRW) begin
            lines[hit_way][i_index] <= wr_line;
        end
        if (do_fill) begin
            lines[victim][i_index] <= i_memory_line;
            tags[victim][i_index]  <= i_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_data  <= '0;
            o_valid <= 1'b0;
        end else begin
            o_valid <= do_hit;
            if (do_hit) o_data <= memRW ? dataW : rd_word;
        end
    end

`ifdef SA_CACHE_WRITEBACK_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_evict      <= 1'b0;
            o_evict_data <= '0;
            o_evict_addr <= '0;
        end else begin
            o_evict <= 1'b0;
            if (do_fill && meta[victim][i_index][META_VALID] && meta[victim][i_index][META_DIRTY]) begin
                o_evict      <= 1'b1;
                o_evict_data <= lines[victim][i_index];
                o_evict_addr <= {tags[victim][i_index], i_index, {OFFSET_BITS{1'b0}}};
            end
        end
    end
`else
    assign o_evict      = 1'b0;
    assign o_evict_data = '0;
    assign o_evict_addr = '0;
`endif

endmodule

// File: tb/tb_sa_cache_core.sv
// Bench for sa_cache_core: miss/fill, write hits, replacement order, dirty eviction,
// stray fill responses and reset while a miss is pending.
module tb_sa_cache_core;

    logic         clk;
    logic         rst_n;
    logic         i_req;
    logic [19:0]  i_tag;
    logic [7:0]   i_index;
    logic [3:0]   i_offset;
    logic         memRW;
    logic [31:0]  dataW;
    logic [127:0] i_memory_line;
    logic         i_memory_response;
    logic [31:0]  o_data;
    logic         o_valid;
    logic [127:0] line_data;
    logic         cache_miss;
    logic         o_evict;
    logic [127:0] o_evict_data;
    logic [31:0]  o_evict_addr;

    int errors = 0;
    int checks = 0;
    logic [31:0]  exp_q[$];
    logic [127:0] ev_data;
    logic [31:0]  ev_addr;

`ifdef SA_CACHE_WRITEBACK_EN
    localparam logic WB = 1'b1;
`else
    localparam logic WB = 1'b0;
`endif

    localparam logic [127:0] SPEC_LINE = 128'h0000_0004_0000_0003_0000_0002_0000_0001;

    sa_cache_core dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .i_req             (i_req),
        .i_tag             (i_tag),
        .i_index           (i_index),
        .i_offset          (i_offset),
        .memRW             (memRW),
        .dataW             (dataW),
        .i_memory_line     (i_memory_line),
        .i_memory_response (i_memory_response),
        .o_data            (o_data),
        .o_valid           (o_valid),
        .line_data         (line_data),
        .cache_miss        (cache_miss),
        .o_evict           (o_evict),
        .o_evict_data      (o_evict_data),
        .o_evict_addr      (o_evict_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory content model: word k of line (tag, index) is {tag, index, k}.
    function automatic logic [127:0] line_for(input logic [19:0] t, input logic [7:0] ix);
        logic [127:0] l;
        for (int k = 0; k < 4; k++) l[k*32 +: 32] = {t, ix, 4'(k)};
        return l;
    endfunction

    function automatic logic [31:0] word_for(input logic [19:0] t, input logic [7:0] ix, input int k);
        return {t, ix, 4'(k)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One request, served by memory with `fill` if it misses; result goes through the scoreboard.
    task automatic access(input logic [19:0] tag, input logic [7:0] idx, input logic [3:0] off,
                          input logic rw, input logic [31:0] wd, input logic [127:0] fill,
                          input logic exp_miss, input logic exp_evict, input logic [31:0] exp_data,
                          input string name);
        logic [31:0] want;
        i_req = 1'b1; i_tag = tag; i_index = idx; i_offset = off; memRW = rw; dataW = wd;
        exp_q.push_back(exp_data);
        step();
        checks++;
        if (cache_miss !== exp_miss) begin
            errors++;
            $display("FAIL %s cache_miss: got %b expected %b", name, cache_miss, exp_miss);
        end
        if (cache_miss) begin
            i_memory_line = fill;
            i_memory_response = 1'b1;
            step();
            i_memory_response = 1'b0;
            checks++;
            if (cache_miss !== 1'b0) begin
                errors++;
                $display("FAIL %s miss_clear: got %b expected 0", name, cache_miss);
            end
            checks++;
            if (o_evict !== exp_evict) begin
                errors++;
                $display("FAIL %s o_evict: got %b expected %b", name, o_evict, exp_evict);
            end
            ev_data = o_evict_data;
            ev_addr = o_evict_addr;
            step();
        end
        i_req = 1'b0;
        checks++;
        if (o_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s o_valid: got %b expected 1", name, o_valid);
            exp_q.delete();
        end else if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s scoreboard: got response %h expected none", name, o_data);
        end else begin
            want = exp_q.pop_front();
            checks++;
            if (o_data !== want) begin
                errors++;
                $display("FAIL %s o_data: got %h expected %h", name, o_data, want);
            end
        end
        step();
        checks++;
        if (o_valid !== 1'b0 || o_evict !== 1'b0) begin
            errors++;
            $display("FAIL %s pulse: got valid=%b evict=%b expected 0 0", name, o_valid, o_evict);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; i_req = 1'b0; i_tag = '0; i_index = '0; i_offset = '0; memRW = 1'b0;
        dataW = '0; i_memory_line = '0; i_memory_response = 1'b0;
        step(); step();
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset o_valid: got %b expected 0", o_valid); end
        checks++; if (o_data !== 32'h0) begin errors++; $display("FAIL reset o_data: got %h expected 0", o_data); end
        checks++; if (cache_miss !== 1'b0) begin errors++; $display("FAIL reset cache_miss: got %b expected 0", cache_miss); end
        checks++; if (o_evict !== 1'b0) begin errors++; $display("FAIL reset o_evict: got %b expected 0", o_evict); end
        checks++; if (o_evict_data !== 128'h0) begin errors++; $display("FAIL reset o_evict_data: got %h expected 0", o_evict_data); end
        checks++; if (o_evict_addr !== 32'h0) begin errors++; $display("FAIL reset o_evict_addr: got %h expected 0", o_evict_addr); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_miss_fill();
        access(20'h1, 8'd3, 4'd4, 1'b0, 32'h0, SPEC_LINE, 1'b1, 1'b0, 32'h0000_0002, "miss_fill");
        access(20'h1, 8'd3, 4'd12, 1'b0, 32'h0, SPEC_LINE, 1'b0, 1'b0, 32'h0000_0004, "hit_off12");
    endtask

    task automatic test_write_hit();
        logic [127:0] exp_line;
        access(20'h1, 8'd3, 4'd8, 1'b1, 32'hDEAD_BEEF, SPEC_LINE, 1'b0, 1'b0, 32'hDEAD_BEEF, "write_hit");
        access(20'h1, 8'd3, 4'd8, 1'b0, 32'h0, SPEC_LINE, 1'b0, 1'b0, 32'hDEAD_BEEF, "read_back");
        exp_line = SPEC_LINE;
        exp_line[95:64] = 32'hDEAD_BEEF;
        checks++;
        if (line_data !== exp_line) begin
            errors++;
            $display("FAIL line_data_hit: got %h expected %h", line_data, exp_line);
        end
        i_tag = 20'h7;
        #1;
        checks++;
        if (line_data !== 128'h0) begin
            errors++;
            $display("FAIL line_data_nohit: got %h expected 0", line_data);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] want;
        logic [31:0] exp_words[4];
        exp_words[0] = 32'h1; exp_words[1] = 32'h2; exp_words[2] = 32'hDEAD_BEEF; exp_words[3] = 32'h4;
        for (int k = 0; k < 4; k++) begin
            i_req = 1'b1; i_tag = 20'h1; i_index = 8'd3; i_offset = 4'(k * 4); memRW = 1'b0;
            exp_q.push_back(exp_words[k]);
            step();
            checks++;
            if (o_valid !== 1'b1 || exp_q.size() == 0) begin
                errors++;
                $display("FAIL b2b_valid%0d: got %b expected 1", k, o_valid);
                exp_q.delete();
            end else begin
                want = exp_q.pop_front();
                checks++;
                if (o_data !== want) begin
                    errors++;
                    $display("FAIL b2b_data%0d: got %h expected %h", k, o_data, want);
                end
            end
        end
        i_req = 1'b0;
        step();
    endtask

    task automatic test_idle_response();
        i_memory_line = {4{32'h5555_AAAA}};
        i_memory_response = 1'b1;
        step();
        i_memory_response = 1'b0;
        checks++;
        if (cache_miss !== 1'b0 || o_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_resp: got miss=%b valid=%b expected 0 0", cache_miss, o_valid);
        end
        access(20'h1, 8'd3, 4'd8, 1'b0, 32'h0, SPEC_LINE, 1'b0, 1'b0, 32'hDEAD_BEEF, "idle_resp_keep");
    endtask

    task automatic test_replacement();
        for (int t = 'h10; t <= 'h13; t++)
            access(20'(t), 8'd5, 4'd0, 1'b0, 32'h0, line_for(20'(t), 8'd5), 1'b1, 1'b0,
                   word_for(20'(t), 8'd5, 0), "fill_set5");
        // all four use bits set: way 0 (tag 0x10) is replaced
        access(20'h14, 8'd5, 4'd4, 1'b0, 32'h0, line_for(20'h14, 8'd5), 1'b1, 1'b0, word_for(20'h14, 8'd5, 1), "fifth_tag");
        // only way 0 is in use now: lowest unused way 1 (tag 0x11) is replaced
        access(20'h15, 8'd5, 4'd0, 1'b0, 32'h0, line_for(20'h15, 8'd5), 1'b1, 1'b0, word_for(20'h15, 8'd5, 0), "sixth_tag");
        access(20'h14, 8'd5, 4'd0, 1'b0, 32'h0, 128'h0, 1'b0, 1'b0, word_for(20'h14, 8'd5, 0), "hit_14");
        access(20'h12, 8'd5, 4'd8, 1'b0, 32'h0, 128'h0, 1'b0, 1'b0, word_for(20'h12, 8'd5, 2), "hit_12");
        access(20'h13, 8'd5, 4'd12, 1'b0, 32'h0, 128'h0, 1'b0, 1'b0, word_for(20'h13, 8'd5, 3), "hit_13");
        // tag 0x11 was evicted; refill it into way 0 after another use sweep
        access(20'h11, 8'd5, 4'd0, 1'b0, 32'h0, line_for(20'h11, 8'd5), 1'b1, 1'b0, word_for(20'h11, 8'd5, 0), "refill_11");
        access(20'h15, 8'd5, 4'd4, 1'b0, 32'h0, 128'h0, 1'b0, 1'b0, word_for(20'h15, 8'd5, 1), "hit_15");
    endtask

    task automatic test_dirty_evict();
        logic [127:0] exp_line;
        // set 5: ways {0x11,0x15,0x12,0x13}, way 0 becomes dirty
        access(20'h11, 8'd5, 4'd4, 1'b1, 32'hCAFE_F00D, 128'h0, 1'b0, 1'b0, 32'hCAFE_F00D, "dirty_write");
        access(20'h12, 8'd5, 4'd0, 1'b0, 32'h0, 128'h0, 1'b0, 1'b0, word_for(20'h12, 8'd5, 0), "touch_12");
        access(20'h13, 8'd5, 4'd0, 1'b0, 32'h0, 128'h0, 1'b0, 1'b0, word_for(20'h13, 8'd5, 0), "touch_13");
        ev_data = '0;
        ev_addr = '0;
        access(20'h16, 8'd5, 4'd0, 1'b0, 32'h0, line_for(20'h16, 8'd5), 1'b1, WB, word_for(20'h16, 8'd5, 0), "evict_fill");
        exp_line = line_for(20'h11, 8'd5);
        exp_line[63:32] = 32'hCAFE_F00D;
        if (!WB) exp_line = '0;
        checks++;
        if (ev_addr !== (WB ? {20'h11, 8'd5, 4'h0} : 32'h0)) begin
            errors++;
            $display("FAIL evict_addr: got %h expected %h", ev_addr, WB ? {20'h11, 8'd5, 4'h0} : 32'h0);
        end
        checks++;
        if (ev_data !== exp_line) begin
            errors++;
            $display("FAIL evict_data: got %h expected %h", ev_data, exp_line);
        end
        access(20'h11, 8'd5, 4'd0, 1'b0, 32'h0, line_for(20'h11, 8'd5), 1'b1, 1'b0, word_for(20'h11, 8'd5, 0), "evicted_misses");
    endtask

    task automatic test_reset_during_miss();
        i_req = 1'b1; i_tag = 20'h30; i_index = 8'd7; i_offset = 4'd0; memRW = 1'b0;
        step();
        checks++;
        if (cache_miss !== 1'b1) begin
            errors++;
            $display("FAIL rdm_enter: got %b expected 1", cache_miss);
        end
        rst_n = 1'b0;
        i_req = 1'b0;
        step();
        rst_n = 1'b1;
        checks++;
        if (cache_miss !== 1'b0 || o_valid !== 1'b0 || o_data !== 32'h0 || o_evict !== 1'b0) begin
            errors++;
            $display("FAIL rdm_outputs: got miss=%b valid=%b data=%h evict=%b expected 0 0 0 0",
                     cache_miss, o_valid, o_data, o_evict);
        end
        i_memory_line = line_for(20'h30, 8'd7);
        i_memory_response = 1'b1;
        step();
        i_memory_response = 1'b0;
        checks++;
        if (cache_miss !== 1'b0 || o_valid !== 1'b0) begin
            errors++;
            $display("FAIL rdm_late_resp: got miss=%b valid=%b expected 0 0", cache_miss, o_valid);
        end
        exp_q.delete();
        access(20'h1, 8'd3, 4'd4, 1'b0, 32'h0, line_for(20'h1, 8'd3), 1'b1, 1'b0, word_for(20'h1, 8'd3, 1), "rdm_refill");
        access(20'h30, 8'd7, 4'd8, 1'b0, 32'h0, line_for(20'h30, 8'd7), 1'b1, 1'b0, word_for(20'h30, 8'd7, 2), "rdm_abandoned");
    endtask

    initial begin
        test_reset();
        test_miss_fill();
        test_write_hit();
        test_back_to_back();
        test_idle_response();
        test_replacement();
        test_dirty_evict();
        test_reset_during_miss();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sa_cache_core.md
# sa_cache_core

Four-way set-associative, write-back, write-allocate data cache sitting between a single requester (CPU load/store port) and a line-granular memory interface. Each cycle it compares the request tag against all ways of the indexed set, serves hits with one-cycle registered latency, and on a miss stalls via `cache_miss` until memory returns the line. It installs the line into a victim way chosen by a per-way use bit and emits dirty victims on an eviction port.

## Interface
- `SETS`, 256, number of sets (2**INDEX_BITS)
- `WAYS`, 4, associativity (fixed 4 in this block)
- `LINE_SIZE_BYTES`, 16, bytes per line
- `TAG_BITS`, 20, tag width
- `INDEX_BITS`, 8, set index width
- `OFFSET_BITS`, 4, byte offset width (log2 LINE_SIZE_BYTES)
- `DATA_WIDTH`, 32, word width
- `ADDRESS_WIDTH`, 32, = TAG_BITS+INDEX_BITS+OFFSET_BITS
- `clk`  in  1  sole clock, rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `i_req`  in  1  request valid this cycle
- `i_tag`  in  TAG_BITS  request tag
- `i_index`  in  INDEX_BITS  request set
- `i_offset`  in  OFFSET_BITS  byte offset, word-aligned (low 2 bits ignored)
- `memRW`  in  1  1 = write, 0 = read
- `dataW`  in  DATA_WIDTH  write data
- `i_memory_line`  in  LINE_SIZE_BYTES*8  fill line from memory
- `i_memory_response`  in  1  fill line valid (one-cycle pulse)
- `o_data`  out  DATA_WIDTH  read data / echoed write data
- `o_valid`  out  1  pulse: o_data valid, request completed
- `line_data`  out  LINE_SIZE_BYTES*8  combinational hit-way line, 0 on no hit
- `cache_miss`  out  1  miss pending, requester must stall
- `o_evict`  out  1  pulse: dirty victim on o_evict_data/addr
- `o_evict_data`  out  LINE_SIZE_BYTES*8  victim line
- `o_evict_addr`  out  ADDRESS_WIDTH  victim line address {victim tag, index, OFFSET_BITS'0}

## Operation
- Per way/set state: valid, dirty, use, tag, line data.
- Hit way = tag equal AND valid; at most one way hits.
- Idle, `i_req`=1, hit: read returns word `offset[OFFSET_BITS-1:2]` of hit line; write stores `dataW` into that word, sets dirty, `o_data`=`dataW`. Hit way use bit set.
- Idle, `i_req`=1, miss: enter MISS; `cache_miss`=1; no array write.
- MISS: wait for `i_memory_response`. Victim = lowest invalid way; else lowest way with use=0; if all use=1, clear use of all ways and pick way 0. Install: data=`i_memory_line`, tag=`i_tag`, valid=1, dirty=0, use=1. If victim valid and dirty: `o_evict`=1 with victim data and victim tag address. Return to IDLE.
- Requester holds address/data/`memRW` stable while `cache_miss`=1; replayed request then hits (write-allocate).
- `i_memory_response` while IDLE: ignored.
- `i_req`=0 in IDLE: no state change, `o_valid`=0.

## Timing
- Hit: request cycle N, `o_data`/`o_valid` registered at N+1.
- Miss: `cache_miss` rises at N+1; response at cycle M installs line at M+1, `cache_miss` falls at M+1; replayed hit at M+1 completes at M+2.
- `o_valid`, `o_evict` are single-cycle pulses.
- Reset (synchronous, `rst_n`=0 at a rising edge): all valid/dirty/use cleared, FSM IDLE, every output register 0 (`o_data`, `o_valid`, `cache_miss`, `o_evict`, `o_evict_data`, `o_evict_addr`). Reset during MISS abandons the fill; a later response is ignored.

## Configuration
- `SA_CACHE_WRITEBACK_EN` defined: dirty tracking and eviction as above.
- Undefined: dirty bit not stored, `o_evict` tied 0, `o_evict_data`/`o_evict_addr` tied 0; victims silently overwritten (external write-through assumed).

## Structure
- Package `sa_cache_pkg`: LINE_SIZE_BITS, LINE_WIDTH, metadata bit positions (valid, dirty, use), FSM state typedef (IDLE, MISS).
- Sub-module `sa_way_match`: per-way tag comparator ANDed with valid, producing one hit bit; instantiated WAYS times; one-hot hit vector drives the line mux.

## Test plan
- Reset, read tag 0x1, index 3 -> `cache_miss`=1 next cycle; response line 0x0000_0004_0000_0003_0000_0002_0000_0001 -> replay offset 4 returns 0x0000_0002, `o_valid` pulse.
- Write 0xDEADBEEF at offset 8 to resident line, then read offset 8 -> 0xDEADBEEF; no memory activity.
- Fill 4 distinct tags into index 5, fifth tag miss -> victim way 0 (all use bits set, cleared), way 0 replaced.
- Dirty victim: write way 0 then force its replacement -> `o_evict`=1 one cycle, `o_evict_addr`={old tag,5,4'h0}, data includes written word.
- Reset asserted during MISS -> `cache_miss`=0 next cycle, all outputs 0, previously filled line now misses.
